// File: rtl/core_block_sequencer_pkg.sv
// Shared types and sizing helpers for the core-side block sequencer.
// Holds the data word type, the sequencer state encoding and the warp-id width.
package core_block_sequencer_pkg;

  localparam int DATA_W        = 32;
  localparam int NUM_WARPS_DEF = 4;
  localparam int WARP_SIZE_DEF = 16;

  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    BLK_IDLE,
    BLK_LAUNCH,
    BLK_RUN,
    BLK_DONE
  } blk_seq_state_t;

  // A single-warp core still needs a one-bit warp id port.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int WARP_ID_W = id_width(NUM_WARPS_DEF);

endpackage

// File: rtl/core_block_sequencer_lane_mask_gen.sv
// Active-lane mask for a warp from the block's thread-count remainder.
// A zero remainder means the warp is full, so every lane is enabled.
module lane_mask_gen
  #(parameter int WARP_SIZE = 16,
    localparam int LOG_WS   = $clog2(WARP_SIZE))
  (input  logic [LOG_WS-1:0]    rem_i,
   output logic [WARP_SIZE-1:0] mask_o);

  always_comb begin
    // NOTE: every bit is assigned on every pass, so no latch can be inferred.
    mask_o = '0;
    for (int i = 0; i < WARP_SIZE; i++) begin
      mask_o[i] = (rem_i == '0) || (LOG_WS'(i) < rem_i);
    end
  end

endmodule

// File: rtl/core_block_sequencer.sv
// Core-side endpoint of the dispatcher->core block handshake: splits a block into
// warps, launches one warp per cycle, tracks completions and raises done.
module core_block_sequencer
  import core_block_sequencer_pkg::*;
  #(parameter int NUM_WARPS = NUM_WARPS_DEF,
    parameter int WARP_SIZE = WARP_SIZE_DEF,
    localparam int WID      = id_width(NUM_WARPS),
    localparam int LOG_WS   = $clog2(WARP_SIZE))
  (input  logic                 clk,
   input  logic                 reset,
   input  logic                 start_i,
   input  data_t                block_id_i,
   input  data_t                threads_per_block_i,
   output logic                 launch_valid_o,
   output logic [WID-1:0]       launch_warp_id_o,
   output data_t                launch_base_tid_o,
   output logic [WARP_SIZE-1:0] launch_lane_mask_o,
   input  logic [NUM_WARPS-1:0] warp_done_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 config_error_o);

  blk_seq_state_t       state_q;
  data_t                prod_q;
  logic [WID:0]         nwarps_q;
  logic [LOG_WS-1:0]    rem_q;
  logic [WID-1:0]       w_q;
  logic [NUM_WARPS-1:0] launched_q;
  logic [NUM_WARPS-1:0] done_mask_q;
  logic                 launch_valid_q;
  logic [WID-1:0]       launch_warp_id_q;
  data_t                launch_base_tid_q;
  logic [WARP_SIZE-1:0] launch_lane_mask_q;
  logic                 done_q;
  logic                 config_error_q;

  data_t                raw_warps;
  logic                 sat;
  logic [WID:0]         nwarps_d;
  logic [NUM_WARPS-1:0] done_mask_d;
  logic [NUM_WARPS-1:0] need_mask;
  logic                 last_launch;
  logic [WARP_SIZE-1:0] tail_mask;

  lane_mask_gen #(.WARP_SIZE(WARP_SIZE)) u_lane_mask (
    .rem_i  (rem_q),
    .mask_o (tail_mask)
  );

  always_comb begin
    raw_warps = data_t'(threads_per_block_i >> LOG_WS)
              + data_t'(|threads_per_block_i[LOG_WS-1:0]);
    sat       = raw_warps > data_t'(NUM_WARPS);
    nwarps_d  = sat ? (WID+1)'(NUM_WARPS) : raw_warps[WID:0];

    // Completions count only for warps whose launch has already been issued.
    done_mask_d = done_mask_q | (warp_done_i & launched_q);

    need_mask = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      need_mask[i] = ((WID+1)'(i) < nwarps_q);
    end

    last_launch = ({1'b0, w_q} == (nwarps_q - (WID+1)'(1)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= BLK_IDLE;
      prod_q             <= '0;
      nwarps_q           <= '0;
      rem_q              <= '0;
      w_q                <= '0;
      launched_q         <= '0;
      done_mask_q        <= '0;
      launch_valid_q     <= 1'b0;
      launch_warp_id_q   <= '0;
      launch_base_tid_q  <= '0;
      launch_lane_mask_q <= '0;
      done_q             <= 1'b0;
      config_error_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every branch reads pre-edge register values.
      launch_valid_q <= 1'b0;
      done_mask_q    <= done_mask_d;

      unique case (state_q)
        BLK_IDLE: begin
          if (start_i) begin
            prod_q      <= block_id_i * threads_per_block_i;
            nwarps_q    <= nwarps_d;
            // A saturated block has no partial tail warp within this core.
            rem_q       <= sat ? '0 : threads_per_block_i[LOG_WS-1:0];
            w_q         <= '0;
            launched_q  <= '0;
            done_mask_q <= '0;
            if (sat) config_error_q <= 1'b1;
            state_q     <= (threads_per_block_i == '0) ? BLK_DONE : BLK_LAUNCH;
          end
        end

        BLK_LAUNCH: begin
          if (!start_i) begin
            launched_q  <= '0;
            done_mask_q <= '0;
            state_q     <= BLK_IDLE;
          end else begin
            launch_valid_q     <= 1'b1;
            launch_warp_id_q   <= w_q;
            launch_base_tid_q  <= prod_q + (data_t'(w_q) << LOG_WS);
            launch_lane_mask_q <= last_launch ? tail_mask : '1;
            launched_q[w_q]    <= 1'b1;
            w_q                <= w_q + WID'(1);
            if (last_launch) state_q <= BLK_RUN;
          end
        end

        BLK_RUN: begin
          if (!start_i) begin
            launched_q  <= '0;
            done_mask_q <= '0;
            state_q     <= BLK_IDLE;
          end else if ((done_mask_d & need_mask) == need_mask) begin
            done_q  <= 1'b1;
            state_q <= BLK_DONE;
          end
        end

        BLK_DONE: begin
          if (!start_i) begin
            done_q      <= 1'b0;
            launched_q  <= '0;
            done_mask_q <= '0;
            state_q     <= BLK_IDLE;
          end else begin
            done_q <= 1'b1;
          end
        end

        default: state_q <= BLK_IDLE;
      endcase
    end
  end

  assign launch_valid_o     = launch_valid_q;
  assign launch_warp_id_o   = launch_warp_id_q;
  assign launch_base_tid_o  = launch_base_tid_q;
  assign launch_lane_mask_o = launch_lane_mask_q;
  assign busy_o             = (state_q == BLK_LAUNCH) || (state_q == BLK_RUN);
  assign done_o             = done_q;
  assign config_error_o     = config_error_q;

endmodule

// File: tb/tb_core_block_sequencer.sv
// Directed bench for core_block_sequencer (4 warps x 16 lanes).
// Each task drives one scenario and compares outputs against hand-computed values.
module tb_core_block_sequencer;
  import core_block_sequencer_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  data_t                block_id;
  data_t                tpb;
  logic [3:0]           warp_done;
  logic                 launch_valid;
  logic [WARP_ID_W-1:0] launch_warp_id;
  data_t                launch_base_tid;
  logic [15:0]          launch_lane_mask;
  logic                 busy;
  logic                 done;
  logic                 config_error;

  int n_cmp = 0;
  int n_bad = 0;

  core_block_sequencer #(.NUM_WARPS(4), .WARP_SIZE(16)) dut (
    .clk                 (clk),
    .reset               (reset),
    .start_i             (start),
    .block_id_i          (block_id),
    .threads_per_block_i (tpb),
    .launch_valid_o      (launch_valid),
    .launch_warp_id_o    (launch_warp_id),
    .launch_base_tid_o   (launch_base_tid),
    .launch_lane_mask_o  (launch_lane_mask),
    .warp_done_i         (warp_done),
    .busy_o              (busy),
    .done_o              (done),
    .config_error_o      (config_error)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; warp_done = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic pulse_done(input logic [3:0] m);
    warp_done = m;
    step();
    warp_done = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; block_id = 32'd9; tpb = 32'd64; warp_done = 4'hF;
    step(); step();
    n_cmp++; if (launch_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %0b want 0", launch_valid); end
    n_cmp++; if (launch_base_tid !== 32'd0) begin n_bad++; $display("FAIL rst_base: got %0d want 0", launch_base_tid); end
    n_cmp++; if (launch_lane_mask !== 16'h0) begin n_bad++; $display("FAIL rst_mask: got %h want 0000", launch_lane_mask); end
    n_cmp++; if ({busy, done, config_error} !== 3'b000) begin n_bad++; $display("FAIL rst_flags: got %b want 000", {busy, done, config_error}); end
    reset = 1'b0; start = 1'b0; warp_done = '0;
  endtask

  task automatic test_full_block();
    do_reset();
    block_id = 32'd3; tpb = 32'd64; start = 1'b1;
    step();
    n_cmp++; if ({busy, launch_valid} !== 2'b10) begin n_bad++; $display("FAIL t1_entry busy/valid: got %b want 10", {busy, launch_valid}); end
    for (int w = 0; w < 4; w++) begin
      step();
      n_cmp++; if (launch_valid !== 1'b1) begin n_bad++; $display("FAIL t1_valid w%0d: got %0b want 1", w, launch_valid); end
      n_cmp++; if (launch_warp_id !== WARP_ID_W'(w)) begin n_bad++; $display("FAIL t1_id w%0d: got %0d want %0d", w, launch_warp_id, w); end
      n_cmp++; if (launch_base_tid !== 32'(192 + 16*w)) begin n_bad++; $display("FAIL t1_base w%0d: got %0d want %0d", w, launch_base_tid, 192 + 16*w); end
      n_cmp++; if (launch_lane_mask !== 16'hFFFF) begin n_bad++; $display("FAIL t1_mask w%0d: got %h want ffff", w, launch_lane_mask); end
    end
    step();
    n_cmp++; if ({busy, launch_valid} !== 2'b10) begin n_bad++; $display("FAIL t1_run busy/valid: got %b want 10", {busy, launch_valid}); end
    for (int w = 0; w < 4; w++) begin
      pulse_done(4'(1 << w));
      n_cmp++; if (done !== (w == 3)) begin n_bad++; $display("FAIL t1_done after wd%0d: got %0b want %0b", w, done, (w == 3)); end
    end
    n_cmp++; if (config_error !== 1'b0) begin n_bad++; $display("FAIL t1_cfgerr: got %0b want 0", config_error); end
    start = 1'b0;
    step();
    n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL t1_release busy/done: got %b want 00", {busy, done}); end
  endtask

  task automatic test_partial_warp();
    do_reset();
    block_id = 32'd0; tpb = 32'd40; start = 1'b1;
    step();
    for (int w = 0; w < 3; w++) begin
      step();
      n_cmp++; if (launch_base_tid !== 32'(16*w)) begin n_bad++; $display("FAIL t2_base w%0d: got %0d want %0d", w, launch_base_tid, 16*w); end
      n_cmp++; if (launch_lane_mask !== ((w == 2) ? 16'h00FF : 16'hFFFF)) begin n_bad++; $display("FAIL t2_mask w%0d: got %h", w, launch_lane_mask); end
    end
    step();
    n_cmp++; if (launch_valid !== 1'b0) begin n_bad++; $display("FAIL t2_no_4th_launch: got %0b want 0", launch_valid); end
    pulse_done(4'b0111);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL t2_done: got %0b want 1", done); end
    step();
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL t2_done_held: got %0b want 1", done); end
    start = 1'b0;
    step();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL t2_done_clear: got %0b want 0", done); end
  endtask

  task automatic test_zero_threads();
    do_reset();
    block_id = 32'd9; tpb = 32'd0; start = 1'b1;
    step();
    n_cmp++; if ({launch_valid, done, busy} !== 3'b000) begin n_bad++; $display("FAIL t3_cycle1 valid/done/busy: got %b want 000", {launch_valid, done, busy}); end
    step();
    n_cmp++; if ({launch_valid, done} !== 2'b01) begin n_bad++; $display("FAIL t3_cycle2 valid/done: got %b want 01", {launch_valid, done}); end
    step();
    n_cmp++; if ({launch_valid, done} !== 2'b01) begin n_bad++; $display("FAIL t3_cycle3 valid/done: got %b want 01", {launch_valid, done}); end
    start = 1'b0;
    step();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL t3_done_clear: got %0b want 0", done); end
  endtask

  task automatic test_overflow();
    do_reset();
    block_id = 32'd1; tpb = 32'd100; start = 1'b1;
    step();
    n_cmp++; if (config_error !== 1'b1) begin n_bad++; $display("FAIL t4_cfgerr: got %0b want 1", config_error); end
    for (int w = 0; w < 4; w++) begin
      step();
      n_cmp++; if ({launch_valid, launch_warp_id} !== {1'b1, WARP_ID_W'(w)}) begin n_bad++; $display("FAIL t4_launch w%0d: got valid %0b id %0d", w, launch_valid, launch_warp_id); end
      n_cmp++; if (launch_base_tid !== 32'(100 + 16*w)) begin n_bad++; $display("FAIL t4_base w%0d: got %0d want %0d", w, launch_base_tid, 100 + 16*w); end
    end
    step();
    n_cmp++; if (launch_valid !== 1'b0) begin n_bad++; $display("FAIL t4_no_5th_launch: got %0b want 0", launch_valid); end
    for (int w = 0; w < 4; w++) begin
      pulse_done(4'(1 << w));
      n_cmp++; if (done !== (w == 3)) begin n_bad++; $display("FAIL t4_done after wd%0d: got %0b want %0b", w, done, (w == 3)); end
    end
    start = 1'b0;
    step();
    n_cmp++; if (config_error !== 1'b1) begin n_bad++; $display("FAIL t4_cfgerr_sticky: got %0b want 1", config_error); end
    do_reset();
    n_cmp++; if (config_error !== 1'b0) begin n_bad++; $display("FAIL t4_cfgerr_reset: got %0b want 0", config_error); end
  endtask

  task automatic test_done_races();
    do_reset();
    block_id = 32'd2; tpb = 32'd64; start = 1'b1;
    step(); step(); step(); step();
    n_cmp++; if ({launch_valid, launch_warp_id} !== {1'b1, WARP_ID_W'(2)}) begin n_bad++; $display("FAIL t5_w2 launch: got valid %0b id %0d", launch_valid, launch_warp_id); end
    warp_done = 4'b1001;
    step();
    warp_done = '0;
    n_cmp++; if (launch_base_tid !== 32'd176) begin n_bad++; $display("FAIL t5_w3_base: got %0d want 176", launch_base_tid); end
    step();
    pulse_done(4'b0010);
    pulse_done(4'b0100);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL t5_spurious_ignored: got %0b want 0", done); end
    step();
    n_cmp++; if ({busy, done} !== 2'b10) begin n_bad++; $display("FAIL t5_still_running busy/done: got %b want 10", {busy, done}); end
    pulse_done(4'b1000);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL t5_done: got %0b want 1", done); end
    start = 1'b0;
    step();
  endtask

  task automatic test_abort();
    do_reset();
    block_id = 32'd4; tpb = 32'd64; start = 1'b1;
    step(); step(); step();
    start = 1'b0;
    step();
    n_cmp++; if ({launch_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL t_abort valid/busy: got %b want 00", {launch_valid, busy}); end
    step(); step();
    n_cmp++; if ({launch_valid, done} !== 2'b00) begin n_bad++; $display("FAIL t_abort_quiet valid/done: got %b want 00", {launch_valid, done}); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    block_id = 32'd1; tpb = 32'd64; start = 1'b1;
    repeat (6) step();
    pulse_done(4'b0001);
    pulse_done(4'b0010);
    n_cmp++; if ({busy, done} !== 2'b10) begin n_bad++; $display("FAIL t6_pre_reset busy/done: got %b want 10", {busy, done}); end
    reset = 1'b1; start = 1'b0;
    step();
    n_cmp++; if ({launch_valid, busy, done, config_error} !== 4'b0000) begin n_bad++; $display("FAIL t6_reset_flags: got %b want 0000", {launch_valid, busy, done, config_error}); end
    n_cmp++; if ({launch_warp_id, launch_base_tid, launch_lane_mask} !== '0) begin n_bad++; $display("FAIL t6_reset_launch_fields: id %0d base %0d mask %h want all 0", launch_warp_id, launch_base_tid, launch_lane_mask); end
    reset = 1'b0;
    step();
    block_id = 32'd5; tpb = 32'd32; start = 1'b1;
    step(); step();
    n_cmp++; if ({launch_valid, launch_base_tid} !== {1'b1, 32'd160}) begin n_bad++; $display("FAIL t6_w0: got valid %0b base %0d want 1/160", launch_valid, launch_base_tid); end
    step();
    n_cmp++; if ({launch_valid, launch_base_tid, launch_lane_mask} !== {1'b1, 32'd176, 16'hFFFF}) begin n_bad++; $display("FAIL t6_w1: got valid %0b base %0d mask %h", launch_valid, launch_base_tid, launch_lane_mask); end
    step();
    pulse_done(4'b0011);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL t6_done: got %0b want 1", done); end
    start = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    do_reset();
    block_id = 32'd7; tpb = 32'd16; start = 1'b1;
    step(); step();
    n_cmp++; if ({launch_valid, launch_base_tid} !== {1'b1, 32'd112}) begin n_bad++; $display("FAIL b2b_first: got valid %0b base %0d want 1/112", launch_valid, launch_base_tid); end
    step();
    pulse_done(4'b0001);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_first_done: got %0b want 1", done); end
    reset = 1'b1; block_id = 32'd8;
    step();
    reset = 1'b0;
    step();
    n_cmp++; if ({busy, done} !== 2'b10) begin n_bad++; $display("FAIL b2b_restart busy/done: got %b want 10", {busy, done}); end
    step();
    n_cmp++; if ({launch_valid, launch_base_tid} !== {1'b1, 32'd128}) begin n_bad++; $display("FAIL b2b_second: got valid %0b base %0d want 1/128", launch_valid, launch_base_tid); end
    start = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_full_block();
    test_partial_warp();
    test_zero_threads();
    test_overflow();
    test_done_races();
    test_abort();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
